// File: rtl/am_demod_pkg.sv
// am_demod_pkg -- shared constants and width helpers for the AM demodulator.
//   abs_limit(iw)      : largest magnitude representable after rectification
//                        (2^(iw-1)-1); the most negative input saturates here.
//   acc_width(iw, dl)  : block accumulator width, wide enough for 2^dl
//                        rectified samples.
//   dc_width(iw, ds)   : DC-tracker accumulator width (envelope scaled by 2^ds).
package am_demod_pkg;

   function automatic int abs_limit(input int iw);
      return (1 << (iw - 1)) - 1;
   endfunction

   function automatic int acc_width(input int iw, input int dl);
      return iw - 1 + dl;
   endfunction

   function automatic int dc_width(input int iw, input int ds);
      return iw - 1 + ds;
   endfunction

endpackage

// File: rtl/am_demodulate_if.sv
// am_demodulate_if -- sample-in / envelope-and-wave-out bundle.
//   sample_valid : qualifies AM_wave
//   AM_wave      : signed carrier samples
//   envelope     : unsigned mean rectified amplitude of the last block
//   wave_out     : signed recovered modulating wave, DC removed
//   out_valid    : one-cycle strobe for a new wave_out
// master = sample source, slave = demodulator.
interface am_demodulate_if #(
   parameter int INPUT_WIDTH  = 12,
   parameter int OUTPUT_WIDTH = 12
);
   logic                           sample_valid;
   logic signed [INPUT_WIDTH-1:0]  AM_wave;
   logic        [INPUT_WIDTH-2:0]  envelope;
   logic signed [OUTPUT_WIDTH-1:0] wave_out;
   logic                           out_valid;

   modport master (output sample_valid, AM_wave,
                   input  envelope, wave_out, out_valid);
   modport slave  (input  sample_valid, AM_wave,
                   output envelope, wave_out, out_valid);
endinterface

// File: rtl/am_demod_dc_block.sv
// am_demod_dc_block -- DC tracker and output stage.
//   clk_in, RST : clock, synchronous active-high reset
//   envelope    : block envelope (unsigned, INPUT_WIDTH-1 bits)
//   strobe      : one-cycle pulse when envelope has just been updated
//   wave_out    : (envelope - dc) widened to OUTPUT_WIDTH, left-justified
//   out_valid   : one-cycle strobe, one cycle after strobe
// dc is a leaky average: dc_acc += envelope - dc_acc>>DC_SHIFT, dc = dc_acc>>DC_SHIFT.
module am_demod_dc_block
   import am_demod_pkg::*;
#(
   parameter int INPUT_WIDTH  = 12,
   parameter int OUTPUT_WIDTH = 12,
   parameter int DC_SHIFT     = 10
) (
   input  logic                           clk_in,
   input  logic                           RST,
   input  logic        [INPUT_WIDTH-2:0]  envelope,
   input  logic                           strobe,
   output logic signed [OUTPUT_WIDTH-1:0] wave_out,
   output logic                           out_valid
);
   localparam int EW = INPUT_WIDTH - 1;
   localparam int DW = dc_width(INPUT_WIDTH, DC_SHIFT);

   logic        [DW-1:0]           dc_acc_q, dc_acc_d;
   logic signed [OUTPUT_WIDTH-1:0] wave_q, wave_d;
   logic                           vld_q, vld_d;
   logic        [EW-1:0]           dc_w;
   logic signed [INPUT_WIDTH-1:0]  diff_w;
   logic signed [OUTPUT_WIDTH-1:0] ext_w;

   always_comb begin
      dc_w     = EW'(dc_acc_q >> DC_SHIFT);
      // both operands are < 2^EW, so the difference always fits INPUT_WIDTH signed
      diff_w   = $signed({1'b0, envelope}) - $signed({1'b0, dc_w});
      ext_w    = OUTPUT_WIDTH'(diff_w);
      dc_acc_d = dc_acc_q;
      wave_d   = wave_q;
      vld_d    = strobe;
      if (strobe) begin
         wave_d   = ext_w <<< (OUTPUT_WIDTH - INPUT_WIDTH);
         // bounded: fixed point is envelope<<DC_SHIFT, below 2^DW
         dc_acc_d = dc_acc_q + DW'(envelope) - DW'(dc_w);
      end
   end

   always_ff @(posedge clk_in) begin
      if (RST) begin
         dc_acc_q <= '0;
         wave_q   <= '0;
         vld_q    <= 1'b0;
      end else begin
         dc_acc_q <= dc_acc_d;
         wave_q   <= wave_d;
         vld_q    <= vld_d;
      end
   end

   assign wave_out  = wave_q;
   assign out_valid = vld_q;

endmodule

// File: rtl/am_demodulate.sv
// am_demodulate -- AM envelope demodulator.
//   clk_in, RST : clock, synchronous active-high reset
//   bus (slave) : sample_valid/AM_wave in; envelope/wave_out/out_valid out
// Pipeline: S1 register input, S2 saturated |x|, S3 block accumulate and
// dump every 2^DECIM_LOG2 valid samples, S4 DC removal (am_demod_dc_block).
// out_valid rises 3 cycles after the S1 edge of a block's last sample.
module am_demodulate
   import am_demod_pkg::*;
#(
   parameter int INPUT_WIDTH  = 12,
   parameter int OUTPUT_WIDTH = 12,
   parameter int DECIM_LOG2   = 8,
   parameter int DC_SHIFT     = 10
) (
   input  logic      clk_in,
   input  logic      RST,
   am_demodulate_if.slave bus
);
   localparam int EW      = INPUT_WIDTH - 1;
   localparam int AW      = acc_width(INPUT_WIDTH, DECIM_LOG2);
   localparam int ABS_LIM = abs_limit(INPUT_WIDTH);
   localparam logic [EW-1:0]          ABS_SAT  = EW'(ABS_LIM);
   localparam logic [INPUT_WIDTH-1:0] S_MIN    = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
   localparam logic [DECIM_LOG2-1:0]  CNT_LAST = '1;

   // vld_pipe_q[0]: S1 valid, vld_pipe_q[1]: S2 valid
   logic [1:0]              vld_pipe_q, vld_pipe_d;
   logic [INPUT_WIDTH-1:0]  s1_data_q, s1_data_d;
   logic [EW-1:0]           abs_q, abs_d;
   logic [AW-1:0]           acc_q, acc_d;
   logic [DECIM_LOG2-1:0]   cnt_q, cnt_d;
   logic [EW-1:0]           env_q, env_d;
   logic                    dump_q, dump_d;
   logic [EW-1:0]           neg_w;
   logic [AW-1:0]           sum_w;
   logic signed [OUTPUT_WIDTH-1:0] wave_w;
   logic                    ovld_w;

   always_comb begin
      vld_pipe_d = {vld_pipe_q[0], bus.sample_valid};
      s1_data_d  = bus.AM_wave;

      // |x| fits EW bits for every negative x except the minimum, which saturates
      neg_w = ~s1_data_q[EW-1:0] + 1'b1;
      if (!s1_data_q[INPUT_WIDTH-1])
         abs_d = s1_data_q[EW-1:0];
      else if (s1_data_q == S_MIN)
         abs_d = ABS_SAT;
      else
         abs_d = neg_w;

      // the dumping sample is folded into the envelope, not into the next block
      sum_w  = acc_q + AW'(abs_q);
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      env_d  = env_q;
      dump_d = 1'b0;
      if (vld_pipe_q[1]) begin
         if (cnt_q == CNT_LAST) begin
            env_d  = EW'(sum_w >> DECIM_LOG2);
            acc_d  = '0;
            cnt_d  = '0;
            dump_d = 1'b1;
         end else begin
            acc_d = sum_w;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (RST) begin
         vld_pipe_q <= '0;
         s1_data_q  <= '0;
         abs_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         env_q      <= '0;
         dump_q     <= 1'b0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         s1_data_q  <= s1_data_d;
         abs_q      <= abs_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         env_q      <= env_d;
         dump_q     <= dump_d;
      end
   end

   am_demod_dc_block #(
      .INPUT_WIDTH  (INPUT_WIDTH),
      .OUTPUT_WIDTH (OUTPUT_WIDTH),
      .DC_SHIFT     (DC_SHIFT)
   ) u_dc (
      .clk_in    (clk_in),
      .RST       (RST),
      .envelope  (env_q),
      .strobe    (dump_q),
      .wave_out  (wave_w),
      .out_valid (ovld_w)
   );

   assign bus.envelope  = env_q;
   assign bus.wave_out  = wave_w;
   assign bus.out_valid = ovld_w;

endmodule

// File: tb/tb_am_demodulate.sv
// tb_am_demodulate -- directed checks with DECIM_LOG2=2, DC_SHIFT=4, 12/12 widths.
module tb_am_demodulate;
   logic clk_in = 1'b0;
   logic RST    = 1'b1;

   am_demodulate_if #(.INPUT_WIDTH(12), .OUTPUT_WIDTH(12)) bus ();

   am_demodulate #(
      .INPUT_WIDTH  (12),
      .OUTPUT_WIDTH (12),
      .DECIM_LOG2   (2),
      .DC_SHIFT     (4)
   ) dut (
      .clk_in (clk_in),
      .RST    (RST),
      .bus    (bus.slave)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   logic rst_d = 1'b1, rst_d2 = 1'b1;
   always @(posedge clk_in) begin
      cyc    <= cyc + 1;
      rst_d  <= RST;
      rst_d2 <= rst_d;
   end

   int total = 0;
   int bad   = 0;
   int rst_strobes = 0;
   int ev_cyc[$], ev_env[$], ev_wave[$], kq[$];

   // strobes during reset or in the release cycle are counted separately
   always @(negedge clk_in) begin
      if (bus.out_valid === 1'b1) begin
         if (RST || rst_d || rst_d2) rst_strobes++;
         else begin
            ev_cyc.push_back(cyc);
            ev_env.push_back(int'(bus.envelope));
            ev_wave.push_back(int'($signed(bus.wave_out)));
         end
      end
   end

   task automatic chk(input string tag, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic signed [11:0] d);
      bus.sample_valid = v;
      bus.AM_wave      = d;
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset(input string nm);
      RST = 1'b1;
      bus.sample_valid = 1'b0;
      bus.AM_wave      = '0;
      repeat (3) begin @(posedge clk_in); #1; end
      chk({nm, "_rst_env"},  int'(bus.envelope), 0);
      chk({nm, "_rst_wave"}, int'($signed(bus.wave_out)), 0);
      chk({nm, "_rst_ovld"}, int'(bus.out_valid), 0);
      RST = 1'b0;
      ev_cyc.delete(); ev_env.delete(); ev_wave.delete(); kq.delete();
   endtask

   // n drives; sample valid every 'step' cycles; data alternates d0/d1
   task automatic feed(input int n, input int step,
                       input logic signed [11:0] d0, input logic signed [11:0] d1);
      int nv = 0;
      for (int i = 0; i < n; i++) begin
         if (i % step == 0) begin
            drive(1'b1, (nv % 2 == 0) ? d0 : d1);
            nv++;
            if (nv % 4 == 0) kq.push_back(cyc);
         end else drive(1'b0, 12'sd0);
      end
      repeat (6) drive(1'b0, 12'sd0);
   endtask

   task automatic check_ev(input string nm, input int n, input int env,
                           input int w0, input int w1, input int w2, input int w3);
      int wexp[4];
      wexp = '{w0, w1, w2, w3};
      chk({nm, "_count"}, ev_cyc.size(), n);
      for (int i = 0; i < n && i < ev_cyc.size() && i < kq.size(); i++) begin
         chk($sformatf("%s_lat%0d", nm, i),  ev_cyc[i] - kq[i], 3);
         chk($sformatf("%s_env%0d", nm, i),  ev_env[i], env);
         chk($sformatf("%s_wave%0d", nm, i), ev_wave[i], wexp[i]);
      end
   endtask

   initial begin
      bus.sample_valid = 1'b0;
      bus.AM_wave      = '0;

      // constant 1000: dc 0, 62, 121, 176 -> wave 1000, 938, 879, 824
      do_reset("const");
      feed(16, 1, 12'sd1000, 12'sd1000);
      check_ev("const", 4, 1000, 1000, 938, 879, 824);
      chk("const_hold_env", int'(bus.envelope), 1000);
      chk("const_hold_wave", int'($signed(bus.wave_out)), 824);

      // alternating sign rectifies to the same envelope and sequence
      do_reset("alt");
      feed(16, 1, 12'sd1000, -12'sd1000);
      check_ev("alt", 4, 1000, 1000, 938, 879, 824);

      // most negative input saturates to 2047; dc after first block 127
      do_reset("sat");
      feed(8, 1, -12'sd2048, -12'sd2048);
      check_ev("sat", 2, 2047, 2047, 1920, 0, 0);

      // valid every other cycle: strobes 8 cycles apart; dc 25 after first
      do_reset("gap");
      feed(16, 2, 12'sd400, 12'sd400);
      check_ev("gap", 2, 400, 400, 375, 0, 0);
      if (ev_cyc.size() >= 2) chk("gap_spacing", ev_cyc[1] - ev_cyc[0], 8);
      else chk("gap_spacing", -1, 8);

      // reset mid-block drops the two 800 samples
      do_reset("mid");
      drive(1'b1, 12'sd800);
      drive(1'b1, 12'sd800);
      RST = 1'b1;
      drive(1'b0, 12'sd0);
      chk("mid_rst_env", int'(bus.envelope), 0);
      RST = 1'b0;
      feed(4, 1, 12'sd200, 12'sd200);
      check_ev("mid", 1, 200, 200, 0, 0, 0);

      chk("rst_strobes", rst_strobes, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/am_demodulate.md
AM_DEMODULATE -- requirements
Module: am_demodulate

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 12, meaning signed AM input sample width.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 12, meaning signed demodulated output width; OUTPUT_WIDTH >= INPUT_WIDTH.
REQ-003 SHALL have parameter DECIM_LOG2, default 8, meaning log2 of samples per envelope output.
REQ-004 SHALL have parameter DC_SHIFT, default 10, meaning DC-tracker time constant as a power-of-two shift.
REQ-005 SHALL have port clk_in  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port sample_valid  input  1  AM_wave qualifier; only qualified samples are processed.
REQ-008 SHALL have port AM_wave  input  INPUT_WIDTH  signed two's-complement AM carrier samples.
REQ-009 SHALL have port envelope  output  INPUT_WIDTH-1  unsigned mean rectified amplitude of the last block.
REQ-010 SHALL have port wave_out  output  OUTPUT_WIDTH  signed recovered modulating wave, DC removed.
REQ-011 SHALL have port out_valid  output  1  one-cycle strobe marking a new wave_out value.

Function
REQ-012 SHALL register AM_wave and sample_valid at stage S1 (edge n).
REQ-013 SHALL compute at S2 (edge n+1) the registered absolute value as INPUT_WIDTH-1 bits unsigned, with -2^(INPUT_WIDTH-1) saturated to 2^(INPUT_WIDTH-1)-1; valid pipelined alongside.
REQ-014 SHALL at S3 (edge n+2), for each valid S2 sample, add it into an accumulator of INPUT_WIDTH-1+DECIM_LOG2 bits and increment a DECIM_LOG2-bit sample counter; invalid cycles hold both.
REQ-015 SHALL, on the valid sample where the counter equals 2^DECIM_LOG2-1 (dump), load envelope with (accumulator + sample) >> DECIM_LOG2, clear accumulator to 0, wrap counter to 0; no sample is lost or double-counted across the dump.
REQ-016 SHALL at S4 (edge after dump) load wave_out with (envelope - dc) as signed INPUT_WIDTH bits, left-shifted by OUTPUT_WIDTH-INPUT_WIDTH, and pulse out_valid high exactly one cycle.
REQ-017 SHALL on the same S4 edge update dc_acc (INPUT_WIDTH-1+DC_SHIFT bits unsigned) as dc_acc + envelope - (dc_acc >> DC_SHIFT), where dc = dc_acc >> DC_SHIFT is the pre-update value.
REQ-018 SHALL have latency of 3 cycles from the S1 edge of the last sample of a block to out_valid high.
REQ-019 SHALL hold envelope and wave_out stable between strobes; out_valid low otherwise.
REQ-020 SHALL keep out_valid strobes spaced by at least 2^DECIM_LOG2 cycles; sample_valid gaps only stretch spacing.

Reset
REQ-021 SHALL on RST clear all pipeline registers, valid flags, accumulator, counter, dc_acc, envelope, wave_out to 0 and out_valid to 0.
REQ-022 SHALL on RST mid-block discard the partial block; the first block after RST release starts at the first valid sample.
REQ-023 SHALL not emit out_valid during RST or in the cycle RST is released.

Structure
REQ-024 SHALL place abs-saturation limit constant and accumulator/dc width derivation functions in shared package am_demod_pkg.
REQ-025 SHALL implement the DC tracker (REQ-016/017) as sub-module am_demod_dc_block with inputs envelope, strobe and outputs wave_out, out_valid.

Verification (DECIM_LOG2=2, DC_SHIFT=4, widths 12/12)
REQ-026 SHALL cover: constant AM_wave=1000, valid always -> envelope=1000; wave_out sequence 1000, 938, 879...; out_valid every 4 cycles, first 3 cycles after 4th sample.
REQ-027 SHALL cover: AM_wave alternating +1000/-1000 -> envelope=1000, identical wave_out sequence to REQ-026.
REQ-028 SHALL cover: AM_wave=-2048 constant -> envelope=2047, no wraparound.
REQ-029 SHALL cover: sample_valid toggling 1010... with AM_wave=400 -> out_valid every 8 cycles, envelope=400.
REQ-030 SHALL cover: RST after 2 of 4 samples of 800, then 4 samples of 200 -> first envelope=200, wave_out=200.
